prbs_checker: RTL and testbench
===============================

PRBS_CHECKER -- requirements
Module: prbs_checker

Interface
REQ-001 Parameter width, default 32, LFSR length in bits, ≥2.
REQ-002 Parameter polynom, default all-zero (width bits), feedback taps of the matching generator.
REQ-003 Parameter LOCK_CNT, default 64, consecutive correct predictions needed to lock, ≥1.
REQ-004 Parameter ERR_LIMIT, default 8, errors within one window that drop lock, ≥1.
REQ-005 Parameter WINDOW, default 256, window length in bits, >ERR_LIMIT.
REQ-006 clk  input  1  single clock; all state updates on rising edge.
REQ-007 res_n  input  1  asynchronous active-low reset.
REQ-008 enable  input  1  d_in is valid this cycle; all state holds when low.
REQ-009 clear  input  1  synchronous clear of all state.
REQ-010 d_in  input  1  serial PRBS bit from the upstream generator.
REQ-011 locked  output  1  high while in LOCKED.
REQ-012 err  output  1  one-cycle pulse per mismatched bit in LOCKED.
REQ-013 err_count  output  16  saturating count of mismatches in LOCKED.

Function
REQ-014 History h[width-1:0] holds the last width accepted bits; h[0] is the newest.
REQ-015 Prediction p = h[width-1] XOR (XOR over k=0..width-2 of polynom[width-2-k] AND h[k]).
REQ-016 States: FILL, HUNT, LOCKED; only enabled cycles advance state, counters or history.
REQ-017 FILL: h shifts in d_in; fill counter increments; after width accepted bits -> HUNT, match counter = 0.
REQ-018 HUNT: h shifts in d_in; if d_in==p and h!=0, match counter +1, else match counter = 0.
REQ-019 HUNT: when the match counter reaches LOCK_CNT -> LOCKED on that edge; window and window-error counters = 0.
REQ-020 All-zero history never counts toward lock: a constant-0 stream stays in HUNT.
REQ-021 LOCKED: h shifts in p, not d_in; d_in!=p asserts err and increments the window-error counter.
REQ-022 LOCKED: window counter runs 0..WINDOW-1 and wraps; at wrap, window-error counter = this bit's error (0 or 1).
REQ-023 LOCKED: when the window-error counter reaches ERR_LIMIT -> FILL on that edge; h, fill counter and match counter = 0.
REQ-024 err, locked and err_count are registered and reflect the bit accepted on the preceding enabled edge (latency 1 cycle).
REQ-025 err is low on every cycle with enable low, and in FILL and HUNT.
REQ-026 err_count saturates at 16'hFFFF, is cleared only by reset or clear, and survives loss of lock.
REQ-027 clear=1 with enable=1: clear wins; d_in is discarded.

Reset
REQ-028 res_n low: state = FILL, h = 0, all counters = 0, locked = 0, err = 0, err_count = 0, asynchronously.
REQ-029 clear high at an edge: same values as reset, synchronously; clear overrides enable.
REQ-030 Reset during LOCKED: locked falls immediately; re-lock requires a full FILL and HUNT.

Configuration
REQ-031 Macro PRBS_CHECKER_ERR_CNT_EN defined: err_count counter is implemented per REQ-026.
REQ-032 Macro PRBS_CHECKER_ERR_CNT_EN undefined: no counter register; err_count is constant 0; err and locked are unchanged.

Verification
Common setup: width=7, polynom=7'b0100000, LOCK_CNT=16, ERR_LIMIT=4, WINDOW=32. The stream is non-zero-seeded and follows REQ-015.
REQ-033 Clean stream with enable=1 -> locked rises at the clock after bit 7+16=23; err stays 0; err_count = 0 after 1000 bits.
REQ-034 Locked, one bit flipped -> exactly one err pulse one cycle later; err_count = 1; locked stays 1; next 100 bits error-free.
REQ-035 Locked, 4 flips within 32 bits -> locked falls after the 4th; re-lock after 23 further clean bits; err_count = 4.
REQ-036 Constant-0 d_in for 200 bits -> locked = 0 throughout; state never leaves HUNT.
REQ-037 Locked, enable toggled 1/0 every cycle -> same lock, err and count results as the continuous case, with time doubled.
REQ-038 clear pulsed mid-LOCKED with enable=1 -> next cycle locked = 0, err_count = 0; d_in of that cycle is ignored; res_n pulse gives identical results asynchronously.

Source files
------------

// File: rtl/prbs_checker.sv
// Serial PRBS checker: FILL history, HUNT for LOCK_CNT correct predictions, then free-run in LOCKED.
// Define PRBS_CHECKER_ERR_CNT_EN to build the saturating err_count register; otherwise err_count is 0.
module prbs_checker #(
    parameter int unsigned      width     = 32,
    parameter logic [width-1:0] polynom   = '0,
    parameter int unsigned      LOCK_CNT  = 64,
    parameter int unsigned      ERR_LIMIT = 8,
    parameter int unsigned      WINDOW    = 256
) (
    input  logic        clk,
    input  logic        res_n,
    input  logic        enable,
    input  logic        clear,
    input  logic        d_in,
    output logic        locked,
    output logic        err,
    output logic [15:0] err_count
);
    localparam int unsigned FW = $clog2(width + 1);
    localparam int unsigned MW = $clog2(LOCK_CNT + 1);
    localparam int unsigned WW = $clog2(WINDOW);
    localparam int unsigned EW = $clog2(ERR_LIMIT + 1);

    localparam logic [FW-1:0] FILL_LAST = FW'(width - 1);
    localparam logic [MW-1:0] LOCK_MAX  = MW'(LOCK_CNT);
    localparam logic [WW-1:0] WIN_LAST  = WW'(WINDOW - 1);
    localparam logic [EW-1:0] ERR_MAX   = EW'(ERR_LIMIT);

    typedef enum logic [1:0] {S_FILL, S_HUNT, S_LOCKED} state_t;

    state_t           state_q, state_d;
    logic [width-1:0] h_q, h_d;
    logic [FW-1:0]    fill_q, fill_d;
    logic [MW-1:0]    match_q, match_d;
    logic [WW-1:0]    win_q, win_d;
    logic [EW-1:0]    werr_q, werr_d;
    logic             err_d;
    logic [width-2:0] taps;
    logic             pred;
    logic             mismatch;

    // taps[k] pairs history bit k with polynom bit width-2-k
    for (genvar k = 0; k < width - 1; k++) begin : g_tap
        assign taps[k] = polynom[width-2-k] & h_q[k];
    end

    assign pred     = h_q[width-1] ^ (^taps);
    assign mismatch = d_in ^ pred;
    assign locked   = (state_q == S_LOCKED);

    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        fill_d  = fill_q;
        match_d = match_q;
        win_d   = win_q;
        werr_d  = werr_q;
        err_d   = 1'b0;
        if (clear) begin
            state_d = S_FILL;
            h_d     = '0;
            fill_d  = '0;
            match_d = '0;
            win_d   = '0;
            werr_d  = '0;
        end else if (enable) begin
            unique case (state_q)
                S_FILL: begin
                    h_d    = {h_q[width-2:0], d_in};
                    fill_d = fill_q + 1'b1;
                    if (fill_q == FILL_LAST) begin
                        state_d = S_HUNT;
                        match_d = '0;
                    end
                end
                S_HUNT: begin
                    h_d = {h_q[width-2:0], d_in};
                    // an all-zero history predicts zeros forever, so it never earns credit
                    if (!mismatch && (h_q != '0)) match_d = match_q + 1'b1;
                    else                          match_d = '0;
                    if (match_d == LOCK_MAX) begin
                        state_d = S_LOCKED;
                        win_d   = '0;
                        werr_d  = '0;
                    end
                end
                S_LOCKED: begin
                    // free-run on our own prediction so line errors never corrupt the history
                    h_d   = {h_q[width-2:0], pred};
                    err_d = mismatch;
                    if (win_q == WIN_LAST) begin
                        win_d  = '0;
                        werr_d = EW'(mismatch);
                    end else begin
                        win_d  = win_q + 1'b1;
                        werr_d = werr_q + EW'(mismatch);
                    end
                    if (werr_d == ERR_MAX) begin
                        state_d = S_FILL;
                        h_d     = '0;
                        fill_d  = '0;
                        match_d = '0;
                    end
                end
                default: state_d = S_FILL;
            endcase
        end
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_q <= S_FILL;
            h_q     <= '0;
            fill_q  <= '0;
            match_q <= '0;
            win_q   <= '0;
            werr_q  <= '0;
            err     <= 1'b0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            fill_q  <= fill_d;
            match_q <= match_d;
            win_q   <= win_d;
            werr_q  <= werr_d;
            err     <= err_d;
        end
    end

`ifdef PRBS_CHECKER_ERR_CNT_EN
    logic [15:0] cnt_q;

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n)                            cnt_q <= '0;
        else if (clear)                        cnt_q <= '0;
        else if (err_d && (cnt_q != 16'hFFFF)) cnt_q <= cnt_q + 16'd1;
    end

    assign err_count = cnt_q;
`else
    assign err_count = 16'h0000;
`endif

endmodule

// File: tb/tb_prbs_checker.sv
// Bench for prbs_checker (width 7, x^7+x^6+1 stream): segment table plus flip, clear and reset sequences.
module tb_prbs_checker;
    localparam int W         = 7;
    localparam int ERR_LIM   = 4;
    localparam int NEVER     = 1 << 30;
`ifdef PRBS_CHECKER_ERR_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk    = 1'b0;
    logic        res_n  = 1'b0;
    logic        enable = 1'b0;
    logic        clear  = 1'b0;
    logic        d_in   = 1'b0;
    logic        locked;
    logic        err;
    logic [15:0] err_count;

    prbs_checker #(
        .width(W), .polynom(7'b0100000), .LOCK_CNT(16), .ERR_LIMIT(ERR_LIM), .WINDOW(32)
    ) dut (
        .clk(clk), .res_n(res_n), .enable(enable), .clear(clear), .d_in(d_in),
        .locked(locked), .err(err), .err_count(err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        locked;
        logic        err;
        logic [15:0] cnt;
        string       name;
    } exp_t;

    typedef struct {
        string name;
        int    flips;
        bit    pre_clear;
        bit    pre_reset;
        int    nbits;
        int    lock_at;
        bit    zero;
        bit    tog;
    } seg_t;

    exp_t        sb[$];
    seg_t        tbl[8];
    int          tests = 0;
    int          fails = 0;
    int          exp_cnt = 0;
    logic [W-1:0] g;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // upstream generator: next bit = g[6] ^ g[0], newest bit at g[0]
    task automatic gen_bit(output logic b);
        b = g[6] ^ g[0];
        g = {g[5:0], b};
    endtask

    task automatic cycle(input logic en, input logic clr, input logic d,
                         input logic el, input logic ee, input string name);
        exp_t e, o;
        @(negedge clk);
        enable = en;
        clear  = clr;
        d_in   = d;
        e.locked = el;
        e.err    = ee;
        e.cnt    = CNT_EN ? exp_cnt[15:0] : 16'd0;
        e.name   = name;
        sb.push_back(e);
        @(posedge clk);
        #1;
        o = sb.pop_front();
        check({o.name, ".locked"}, {15'd0, locked}, {15'd0, o.locked});
        check({o.name, ".err"}, {15'd0, err}, {15'd0, o.err});
        check({o.name, ".err_count"}, err_count, o.cnt);
    endtask

    task automatic send(input bit flip, input bit zero, input logic el, input logic ee,
                        input bit tog, input string name);
        logic b;
        if (zero) b = 1'b0;
        else      gen_bit(b);
        if (ee && exp_cnt < 65535) exp_cnt++;
        cycle(1'b1, 1'b0, b ^ flip, el, ee, name);
        if (tog) cycle(1'b0, 1'b0, 1'($urandom_range(0, 1)), el, 1'b0, {name, "_idle"});
    endtask

    task automatic do_reset(input string name);
        @(negedge clk);
        enable = 1'b0;
        clear  = 1'b0;
        check({name, ".pre_locked"}, {15'd0, locked}, 16'd1);
        #2 res_n = 1'b0;
        #1;
        exp_cnt = 0;
        check({name, ".async_locked"}, {15'd0, locked}, 16'd0);
        check({name, ".async_err"}, {15'd0, err}, 16'd0);
        check({name, ".async_err_count"}, err_count, 16'd0);
        @(negedge clk);
        res_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic cb;
        //          name          flips clr rst nbits lock_at zero tog
        tbl[0] = '{"lock",        0,    0,  0,  1000, 23,     0,   0};
        tbl[1] = '{"flip1",       1,    0,  0,  100,  0,      0,   0};
        tbl[2] = '{"clear",       0,    1,  0,  40,   23,     0,   0};
        tbl[3] = '{"flip4",       4,    0,  0,  30,   23,     0,   0};
        tbl[4] = '{"reset",       0,    0,  1,  60,   23,     0,   0};
        tbl[5] = '{"tog_flip1",   1,    0,  0,  30,   0,      0,   1};
        tbl[6] = '{"tog_flip4",   4,    0,  0,  30,   23,     0,   1};
        tbl[7] = '{"zero",        0,    1,  0,  200,  NEVER,  1,   0};

        g = 7'h01;
        #1;
        check("reset.locked", {15'd0, locked}, 16'd0);
        check("reset.err", {15'd0, err}, 16'd0);
        check("reset.err_count", err_count, 16'd0);
        repeat (2) @(negedge clk);
        res_n = 1'b1;

        for (int s = 0; s < 8; s++) begin
            if (tbl[s].pre_clear) begin
                // clear wins over enable; the inverted bit must be discarded
                exp_cnt = 0;
                gen_bit(cb);
                cycle(1'b1, 1'b1, ~cb, 1'b0, 1'b0, {tbl[s].name, "_pulse"});
            end
            if (tbl[s].pre_reset) do_reset(tbl[s].name);
            for (int f = 1; f <= tbl[s].flips; f++)
                send(1'b1, 1'b0, f < ERR_LIM, 1'b1, tbl[s].tog, {tbl[s].name, "_flip"});
            for (int i = 1; i <= tbl[s].nbits; i++)
                send(1'b0, tbl[s].zero, i >= tbl[s].lock_at, 1'b0, tbl[s].tog, tbl[s].name);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
